// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, default widths and wait-counter helpers.
package mem_responder_pkg;
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_DEPTH_LOG2_DEFAULT = 10;
  localparam int MEM_LATENCY_DEFAULT = 2;
  localparam int MEM_CNT_WIDTH = 4;
  typedef logic [MEM_CNT_WIDTH-1:0] mem_cnt_t;
  function automatic mem_cnt_t wait_init(input int latency);
    return MEM_CNT_WIDTH'(latency - 1);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: four-phase READ/WRITE memory handshake between requester and responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
);
  logic                  READ;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  READY;
  logic                  BUSY;
  logic                  ERR;
  modport master (output READ, WRITE, ADDR, DATA_IN, input DATA_OUT, READY, BUSY, ERR);
  modport slave (input READ, WRITE, ADDR, DATA_IN, output DATA_OUT, READY, BUSY, ERR);
endinterface

// File: rtl/mem_array.sv
// mem_array: synchronous single-port RAM with registered read and no reset.
module mem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word read/write responder with programmable wait states and a four-phase READY handshake.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEFAULT,
  parameter int LATENCY    = MEM_LATENCY_DEFAULT
) (
  input logic CLK,
  input logic RST,
  mem_responder_if.slave bus
);
  localparam mem_cnt_t CNT_INIT = wait_init(LATENCY);
  mem_state_e            state_q, state_d;
  mem_cnt_t              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  req, oor, fire, we, re;
  logic [DATA_WIDTH-1:0] rdata;
  assign req  = bus.READ | bus.WRITE;
  assign oor  = |(bus.ADDR >> DEPTH_LOG2);
  // a reset landing on the access edge must abort, so the strobes are gated by RST
  assign fire = (state_q == MEM_WAIT) && (cnt_q == '0) && !RST;
  assign we   = fire && wr_q && !err_q;
  assign re   = fire && !wr_q && !err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    err_d      = err_q;
    rd_valid_d = re ? 1'b1 : rd_valid_q;
    unique case (state_q)
      MEM_IDLE: if (req) begin
        state_d = MEM_WAIT;
        cnt_d   = CNT_INIT;
        addr_d  = bus.ADDR[DEPTH_LOG2-1:0];
        data_d  = bus.DATA_IN;
        wr_d    = bus.WRITE;
        err_d   = (bus.READ & bus.WRITE) | oor;
      end
      MEM_WAIT: begin
        cnt_d   = (cnt_q != '0) ? cnt_q - mem_cnt_t'(1) : cnt_q;
        state_d = (cnt_q != '0) ? MEM_WAIT : MEM_DONE;
      end
      MEM_DONE: if (!req) begin
        state_d = MEM_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = MEM_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .CLK  (CLK),
    .we   (we),
    .re   (re),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(rdata)
  );
  // the array read register holds between reads; rd_valid_q masks it to zero after reset
  assign bus.DATA_OUT = rd_valid_q ? rdata : '0;
  assign bus.READY    = (state_q == MEM_DONE);
  assign bus.BUSY     = (state_q == MEM_WAIT);
  assign bus.ERR      = (state_q == MEM_DONE) && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus corner sequences for three LATENCY settings.
module tb_mem_responder;
  localparam int LATS [3] = '{2, 1, 15};
  logic        clk, rst, rd, wr;
  logic [25:0] addr;
  logic [31:0] din;
  logic [2:0]  rdy_a, busy_a, err_a;
  logic [31:0] dout_a [3];
  int          tests = 0;
  int          fails = 0;
  mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bi [3] ();
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    assign bi[g].READ    = rd;
    assign bi[g].WRITE   = wr;
    assign bi[g].ADDR    = addr;
    assign bi[g].DATA_IN = din;
    assign rdy_a[g]      = bi[g].READY;
    assign busy_a[g]     = bi[g].BUSY;
    assign err_a[g]      = bi[g].ERR;
    assign dout_a[g]     = bi[g].DATA_OUT;
    mem_responder #(
      .ADDR_WIDTH(26),
      .DATA_WIDTH(32),
      .DEPTH_LOG2(10),
      .LATENCY   (LATS[g])
    ) u_dut (
      .CLK(clk),
      .RST(rst),
      .bus(bi[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        r;
    logic        w;
    logic [25:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;
  vec_t vecs [14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_idle(input string nm, input int s, input logic [31:0] exp_dout);
    chk({nm, "_ready"}, 32'(rdy_a[s]), 32'd0);
    chk({nm, "_busy"}, 32'(busy_a[s]), 32'd0);
    chk({nm, "_err"}, 32'(err_a[s]), 32'd0);
    chk({nm, "_dout"}, dout_a[s], exp_dout);
  endtask
  task automatic txn(input string nm, input int s, input logic r, input logic w,
                     input logic [25:0] a, input logic [31:0] d, input logic [31:0] exp_dout,
                     input logic exp_err, input int hold, input bit early);
    int lat, bc;
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
    if (early) begin rd = 1'b0; wr = 1'b0; end
    lat = 0;
    bc  = 0;
    while (!rdy_a[s] && lat < 40) begin
      if (busy_a[s]) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LATS[s]));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(LATS[s]));
    chk({nm, "_err"}, 32'(err_a[s]), 32'(exp_err));
    chk({nm, "_dout"}, dout_a[s], exp_dout);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_hold_ready"}, 32'(rdy_a[s]), 32'd1);
      chk({nm, "_hold_busy"}, 32'(busy_a[s]), 32'd0);
      chk({nm, "_hold_dout"}, dout_a[s], exp_dout);
    end
    rd = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle({nm, "_release"}, s, exp_dout);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 26'h005,     32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 26'h005,     32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 26'h000,     32'h11111111, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 26'h3FF,     32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 26'h007,     32'h01234567, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 26'h3FF,     32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 26'h000,     32'h0,        32'h11111111, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 26'h005,     32'hFFFFFFFF, 32'h11111111, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 26'h400,     32'h0,        32'h11111111, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 26'h400,     32'h12345678, 32'h11111111, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 26'h000,     32'h0,        32'h11111111, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 26'h005,     32'h0,        32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 26'h2000000, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 26'h007,     32'h0,        32'h01234567, 1'b0};
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    do_reset();
    for (int s = 0; s < 3; s++) chk_idle($sformatf("reset%0d", s), s, 32'h0);
    for (int i = 0; i < 14; i++)
      txn($sformatf("v%0d", i), 0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
          vecs[i].exp_dout, vecs[i].exp_err, 0, 1'b0);
    // READ held four cycles past READY, then an early-dropped request that must still complete
    txn("hold", 0, 1'b1, 1'b0, 26'h005, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1'b0);
    txn("early", 0, 1'b1, 1'b0, 26'h3FF, 32'h0, 32'hA5A5A5A5, 1'b0, 0, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      wr = 1'b1; addr = 26'h007; din = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0;
      if (k == 2) begin
        @(posedge clk);
        @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_idle($sformatf("abort%0d", k), 0, 32'h0);
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("abort%0d_no_ready", k), 32'(rdy_a[0]), 32'd0);
      end
      txn($sformatf("abort%0d_readback", k), 0, 1'b1, 1'b0, 26'h007, 32'h0, 32'h01234567, 1'b0, 0, 1'b0);
    end
    for (int s = 1; s <= 2; s++) begin
      do_reset();
      txn($sformatf("sweep%0d_wr", s), s, 1'b0, 1'b1, 26'h001, 32'h0BADF00D + 32'(s), 32'h0, 1'b0, 0, 1'b0);
      txn($sformatf("sweep%0d_rd", s), s, 1'b1, 1'b0, 26'h001, 32'h0, 32'h0BADF00D + 32'(s), 1'b0, 0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's READ/WRITE memory interface: accepts one word read or write per request, inserts a programmable number of wait states, then acknowledges.
- Sits between the control unit/data path memory port and a word-addressed storage array.
- Uses a four-phase level handshake, so the processor FSM can stall in its FETCH/MEM phases until READY.

Parameters:
- ADDR_WIDTH, 26: width of the word address from the processor.
- DATA_WIDTH, 32: word width.
- DEPTH_LOG2, 10: log2 of the implemented words (1024). The implemented range is ADDR[DEPTH_LOG2-1:0].
- LATENCY, 2: wait cycles from request acceptance to READY. Legal range is 1..15.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- RST, input, 1: synchronous, active-high reset.
- READ, input, 1: read request level; held by the requester until READY.
- WRITE, input, 1: write request level; held by the requester until READY.
- ADDR, input, ADDR_WIDTH: word address; sampled when the request is accepted.
- DATA_IN, input, DATA_WIDTH: write data; sampled when the request is accepted.
- DATA_OUT, output, DATA_WIDTH: read data; valid while READY=1 for a read, then held.
- READY, output, 1: completion acknowledge.
- BUSY, output, 1: a transaction is in progress (WAIT state).
- ERR, output, 1: the completed transaction was rejected.

Behaviour:
- Reset values: when RST=1 at a rising edge, state is IDLE, DATA_OUT=0, READY=0, BUSY=0, ERR=0, and the wait counter is 0.
  - Array contents are not affected by reset.
  - Reset in WAIT aborts the transaction. A pending write is not committed.
- States: IDLE, WAIT, DONE. The encoding lives in the package.
- IDLE:
  - If READ or WRITE is high at an edge: latch ADDR, DATA_IN, and the operation type; load cnt=LATENCY-1; go to WAIT with BUSY=1.
  - If both READ and WRITE are high: latch the error flag and take the same WAIT path, but perform no access.
  - If ADDR has any bit set at or above DEPTH_LOG2: latch the error flag and perform no access.
- WAIT:
  - If cnt!=0: decrement.
  - If cnt==0, perform the access on that edge:
    - Write: array[addr] <= data.
    - Read: DATA_OUT <= array[addr].
    - Error: no access, and DATA_OUT is unchanged.
  - Then go to DONE with READY=1, BUSY=0, and ERR equal to the latched error flag.
- Latency: with acceptance at edge k, READY is high after edge k+LATENCY.
  - The request inputs are ignored during WAIT. A requester that drops READ/WRITE early does not cancel the transaction.
- DONE:
  - READY stays high while READ or WRITE stays high.
  - When both are low at an edge: READY=0, ERR=0, go to IDLE.
  - A new request is therefore never accepted without an intervening low phase (no back-to-back re-trigger).
- DATA_OUT holds its last read value across writes, errors, and idle periods.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Only the low DEPTH_LOG2 address bits index the array. Out-of-range addresses never alias.

Decomposition:
- Shared package (include file alongside prj_definition.v):
  - state encoding constants MEM_IDLE, MEM_WAIT, MEM_DONE (2-bit);
  - MEM_DATA_WIDTH and MEM_ADDR_WIDTH defaults;
  - MEM_LATENCY_DEFAULT.
- One sub-module, mem_array: a synchronous single-port RAM.
  - Ports: CLK, we, re, addr[DEPTH_LOG2-1:0], wdata, rdata.
  - Registered read; no reset.
- mem_responder contains the FSM, counter, request latches, and error logic.

Test Plan:
- Write then read, LATENCY=2: write ADDR=0x05, DATA_IN=0xDEADBEEF, then READ ADDR=0x05 → READY rises exactly 2 edges after acceptance each time; second transaction gives DATA_OUT=0xDEADBEEF, ERR=0.
- Handshake hold: keep READ high 4 cycles after READY → READY stays 1 and no second access occurs. Drop READ → READY=0 next edge, state IDLE, BUSY=0.
- Simultaneous READ=WRITE=1, ADDR=0x05 → ERR=1 with READY after 2 edges; a later read of 0x05 still returns 0xDEADBEEF, and DATA_OUT is unchanged in between.
- Out-of-range: READ at ADDR=0x400 (DEPTH_LOG2=10) → ERR=1, no access. Write 0x12345678 to 0x400 → address 0x000 is unmodified.
- Reset mid-operation: write 0xCAFEF00D to 0x07, assert RST one edge after acceptance → READY never rises, outputs are at reset values, and a later read of 0x07 returns the old contents.
- Latency sweep: for LATENCY=1 and LATENCY=15, READY rises after exactly 1 and 15 edges, and BUSY is high for exactly LATENCY cycles.
